// File: rtl/io_bus_sequencer_pkg.sv
// Shared types for the IO bus sequencer: FSM state encoding and the requester
// tag fields used to build the opaque tag at the instantiation site.
package io_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } io_seq_state_t;

  localparam int CORE_ID_WIDTH    = 4;
  localparam int THREAD_IDX_WIDTH = 4;

  typedef logic [CORE_ID_WIDTH-1:0]    core_id_t;
  typedef logic [THREAD_IDX_WIDTH-1:0] thread_idx_t;

  function automatic logic [CORE_ID_WIDTH+THREAD_IDX_WIDTH-1:0] make_tag(
    input core_id_t    core_id,
    input thread_idx_t thread_idx
  );
    return {core_id, thread_idx};
  endfunction

endpackage

// File: rtl/io_bus_sequencer_timeout_counter.sv
// Saturating cycle counter for the sequencer's timeout. A clear cycle counts
// as the first cycle; terminal_o flags the cycle that would be the LIMIT-th.
module io_timeout_counter
  import io_bus_sequencer_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW:0] LIMIT_W = (CW + 1)'(LIMIT);
  localparam logic [CW:0] ONE_W   = (CW + 1)'(1'b1);

  logic [CW-1:0] count_q, count_d;
  logic [CW:0]   count_next_s;

  assign count_next_s = {1'b0, count_q} + ONE_W;

  // Next count: restart at one on clear, otherwise count up without wrapping.
  always_comb begin
    count_d    = count_q;
    terminal_o = 1'b0;
    if (clear_i) begin
      count_d    = CW'(1'b1);
      terminal_o = (LIMIT_W == ONE_W);
    end else if (enable_i) begin
      terminal_o = (count_next_s == LIMIT_W);
      if (count_next_s <= LIMIT_W) begin
        count_d = count_next_s[CW-1:0];
      end else begin
        count_d = count_q;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/io_bus_sequencer.sv
// Sequences one IO transaction at a time onto the external bus, waiting for the
// peripheral's ack or timing out, and always returns exactly one tagged response.
module io_bus_sequencer
  import io_bus_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TAG_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic [31:0]          req_address,
  input  logic [31:0]          req_write_data,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 io_read_en,
  output logic                 io_write_en,
  output logic [31:0]          io_address,
  output logic [31:0]          io_write_data,
  input  logic [31:0]          io_read_data,
  input  logic                 io_ack,
  output logic                 rsp_valid,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic [31:0]          rsp_read_value,
  output logic                 rsp_error
);

  io_seq_state_t        state_q, state_d;
  logic                 is_store_q, is_store_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 cnt_clear_s, cnt_en_s, cnt_terminal_s;

  io_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (cnt_clear_s),
    .enable_i  (cnt_en_s),
    .terminal_o(cnt_terminal_s)
  );

  // Next-state logic; ack outranks a timeout landing on the same cycle.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tag_d       = tag_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_clear_s = 1'b0;
    cnt_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = ISSUE;
          is_store_d = req_is_store;
          addr_d     = req_address;
          wdata_d    = req_write_data;
          tag_d      = req_tag;
          rdata_d    = 32'd0;
          err_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE, WAIT: begin
        cnt_clear_s = (state_q == ISSUE);
        cnt_en_s    = (state_q == WAIT);
        if (io_ack) begin
          state_d = RESPOND;
          rdata_d = is_store_q ? 32'd0 : io_read_data;
        end else if (cnt_terminal_s) begin
          state_d = RESPOND;
          err_d   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      tag_q      <= '0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tag_q      <= tag_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign io_read_en     = (state_q == ISSUE) && !is_store_q;
  assign io_write_en    = (state_q == ISSUE) && is_store_q;
  assign io_address     = addr_q;
  assign io_write_data  = wdata_q;
  assign rsp_valid      = (state_q == RESPOND);
  assign rsp_tag        = tag_q;
  assign rsp_read_value = rdata_q;
  assign rsp_error      = err_q;

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Randomized bench for io_bus_sequencer: the expected response cycle and payload
// of each transaction are derived from the ack delay and the timeout limit.
module tb_io_bus_sequencer;
  import io_bus_sequencer_pkg::*;

  localparam int T  = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_is_store;
  logic [31:0]   req_address, req_write_data;
  logic [TW-1:0] req_tag;
  logic          io_read_en, io_write_en;
  logic [31:0]   io_address, io_write_data, io_read_data;
  logic          io_ack;
  logic          rsp_valid, rsp_error;
  logic [TW-1:0] rsp_tag;
  logic [31:0]   rsp_read_value;

  int checks = 0;
  int errors = 0;

  io_bus_sequencer #(
    .TIMEOUT_CYCLES(T),
    .TAG_WIDTH     (TW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_address   (req_address),
    .req_write_data(req_write_data),
    .req_tag       (req_tag),
    .io_read_en    (io_read_en),
    .io_write_en   (io_write_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .io_ack        (io_ack),
    .rsp_valid     (rsp_valid),
    .rsp_tag       (rsp_tag),
    .rsp_read_value(rsp_read_value),
    .rsp_error     (rsp_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string ctx);
    check_eq({ctx, "_req_ready"}, req_ready, 64'd1);
    check_eq({ctx, "_read_en"}, io_read_en, 64'd0);
    check_eq({ctx, "_write_en"}, io_write_en, 64'd0);
    check_eq({ctx, "_rsp_valid"}, rsp_valid, 64'd0);
    check_eq({ctx, "_rsp_error"}, rsp_error, 64'd0);
    check_eq({ctx, "_io_address"}, io_address, 64'd0);
    check_eq({ctx, "_io_wdata"}, io_write_data, 64'd0);
    check_eq({ctx, "_rsp_tag"}, rsp_tag, 64'd0);
    check_eq({ctx, "_rsp_value"}, rsp_read_value, 64'd0);
  endtask

  // k = ack offset in cycles after the strobe (k >= T means the access times out).
  task automatic run_txn(input logic st, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input logic [TW-1:0] tag,
                         input int k, input bit late);
    int  rsp_j;
    bit  err;
    int  guard;
    if (k <= T - 1) begin
      rsp_j = 2 + k;
      err   = 1'b0;
    end else begin
      rsp_j = 1 + T;
      err   = 1'b1;
    end
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("ready_before_req", req_ready, 64'd1);
    req_valid      = 1'b1;
    req_is_store   = st;
    req_address    = addr;
    req_write_data = data;
    req_tag        = tag;
    @(posedge clk);
    #1;
    req_valid      = 1'b0;
    req_is_store   = 1'($urandom);
    req_address    = $urandom;
    req_write_data = $urandom;
    req_tag        = TW'($urandom);
    for (int j = 1; j <= rsp_j + 3; j++) begin
      @(negedge clk);
      check_eq("read_en", io_read_en, 64'((j == 1) && !st));
      check_eq("write_en", io_write_en, 64'((j == 1) && st));
      check_eq("io_address", io_address, 64'(addr));
      check_eq("io_wdata", io_write_data, 64'(data));
      check_eq("rsp_valid", rsp_valid, 64'(j == rsp_j));
      check_eq("req_ready", req_ready, 64'(j > rsp_j));
      if (j == rsp_j) begin
        check_eq("rsp_tag", rsp_tag, 64'(tag));
        check_eq("rsp_value", rsp_read_value, (err || st) ? 64'd0 : 64'(rdata));
        check_eq("rsp_error", rsp_error, 64'(err));
      end
      io_ack       = (j == 1 + k) || (late && (j == rsp_j + 1 || j == rsp_j + 2));
      io_read_data = (j == 1 + k) ? rdata : $urandom;
    end
    io_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] cur_tag;
    logic [TW-1:0] popped;
    int accepted, responses, last_acc;

    reset          = 1'b1;
    req_valid      = 1'b0;
    req_is_store   = 1'b0;
    req_address    = 32'd0;
    req_write_data = 32'd0;
    req_tag        = '0;
    io_read_data   = 32'd0;
    io_ack         = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Directed cases from the test plan.
    run_txn(1'b0, 32'h110, 32'h0, 32'hDEADBEEF, 8'h3C, 0, 1'b0);
    run_txn(1'b1, 32'h20, 32'h55, 32'h12345678, 8'h41, 3, 1'b0);
    run_txn(1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 8'h77, T + 5, 1'b1);
    run_txn(1'b0, 32'h304, 32'h0, 32'hA1B2C3D4, 8'h78, T - 1, 1'b0);
    run_txn(1'b1, 32'h308, 32'h99, 32'h0BADF00D, 8'h79, T + 5, 1'b0);

    // Back-to-back reads with req_valid held and a zero-wait peripheral.
    @(negedge clk);
    io_ack    = 1'b1;
    req_valid = 1'b1;
    req_is_store = 1'b0;
    req_tag   = 8'h01;
    cur_tag   = 8'h01;
    accepted  = 0;
    responses = 0;
    last_acc  = -1;
    for (int c = 0; c < 40 && responses < 4; c++) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("b2b_extra_rsp", 64'd1, 64'd0);
        end else begin
          popped = exp_q.pop_front();
          check_eq("b2b_tag", rsp_tag, 64'(popped));
          check_eq("b2b_value", rsp_read_value, {32'd0, 24'hA5A5A5, popped});
          check_eq("b2b_error", rsp_error, 64'd0);
        end
        responses++;
      end
      if (req_ready && req_valid) begin
        exp_q.push_back(req_tag);
        cur_tag = req_tag;
        io_read_data = {24'hA5A5A5, cur_tag};
        if (last_acc >= 0) check_eq("b2b_spacing", 64'(c - last_acc), 64'd3);
        last_acc = c;
        accepted++;
        @(posedge clk);
        #1;
        if (accepted == 4) req_valid = 1'b0;
        else req_tag = cur_tag + 8'h01;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    check_eq("b2b_accepted", 64'(accepted), 64'd4);
    check_eq("b2b_responses", 64'(responses), 64'd4);
    io_ack    = 1'b0;
    req_valid = 1'b0;

    // Reset in the middle of WAIT: outputs clear asynchronously, no response.
    @(negedge clk);
    req_valid = 1'b1;
    req_is_store = 1'b1;
    req_address = 32'h4000;
    req_write_data = 32'h1111;
    req_tag = 8'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("post_reset_no_rsp", rsp_valid, 64'd0);
    end
    run_txn(1'b0, 32'h110, 32'h0, 32'h600DCAFE, 8'h22, 1, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              make_tag(core_id_t'($urandom), thread_idx_t'($urandom)),
              $urandom_range(0, T + 1), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
